// File: rtl/debounce_pkg.sv
// Shared types and default parameter values for the input debouncer and its
// synchroniser.
package debounce_pkg;

  typedef enum logic {STABLE, WAIT} db_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Generic multi-flop synchroniser for an asynchronous level; the last stage is
// the clk-domain copy. Reused for other asynchronous inputs.
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises a raw switch level and commits a change to d_out only after it
// has been stable for DEBOUNCE_CYCLES clocks. Optional DEBOUNCE_EDGE_EN adds
// registered rise/fall pulses aligned with the new d_out.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic d_out,
  output logic busy
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise_pulse,
  output logic fall_pulse
`endif
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  db_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            d_out_nxt;
  logic            sync;
  logic            differ;
  logic            commit;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d_in),
    .q     (sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= '0;
      d_out <= RESET_VAL;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      d_out <= d_out_nxt;
    end
  end

  assign differ = (sync != d_out);

  // A reversal back to d_out in WAIT drops the partial count entirely.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      STABLE: begin
        if (differ) begin
          if (DEBOUNCE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT: begin
        if (!differ) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          commit    = 1'b1;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
    d_out_nxt = commit ? sync : d_out;
  end

  always_comb begin
    busy = (state == WAIT);
  end

`ifdef DEBOUNCE_EDGE_EN
  // Registered on the commit edge so each pulse lines up with the new d_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= commit & sync;
      fall_pulse <= commit & ~sync;
    end
  end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: default build (DEBOUNCE_CYCLES=4) and a
// DEBOUNCE_CYCLES=1 build driven from the same input.
module tb_input_debouncer;

  localparam int SS = 2;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic d_in;
  logic dout_a, busy_a, dout_b, busy_b;
`ifdef DEBOUNCE_EDGE_EN
  logic rise_a, fall_a, rise_b, fall_b;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  logic model;
  logic [3:0] exp_q[$];
  logic [3:0] exp1_q[$];
  logic [3:0] e_a, e_b;

  // clock / reset
  always #5 clk = ~clk;

  input_debouncer #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC),
    .RESET_VAL       (1'b0)
  ) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .d_out      (dout_a),
    .busy       (busy_a)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .rise_pulse (rise_a),
    .fall_pulse (fall_a)
`endif
  );

  input_debouncer #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (1),
    .RESET_VAL       (1'b0)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .d_out      (dout_b),
    .busy       (busy_b)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .rise_pulse (rise_b),
    .fall_pulse (fall_b)
`endif
  );

  function automatic logic [3:0] act_a();
`ifdef DEBOUNCE_EDGE_EN
    return {rise_a, fall_a, busy_a, dout_a};
`else
    return {2'b00, busy_a, dout_a};
`endif
  endfunction

  function automatic logic [3:0] act_b();
`ifdef DEBOUNCE_EDGE_EN
    return {rise_b, fall_b, busy_b, dout_b};
`else
    return {2'b00, busy_b, dout_b};
`endif
  endfunction

  function automatic logic [3:0] mask_pulses(logic [3:0] x);
`ifdef DEBOUNCE_EDGE_EN
    return x;
`else
    return {2'b00, x[1:0]};
`endif
  endfunction

  // Expected {rise, fall, busy, d_out} after edge i of a segment: input held at
  // v for len cycles, then (if back) returned to old. Built from the latency
  // rule: commit at edge SS+dc-1 after the first edge seeing a new level.
  function automatic logic [3:0] exp_at(int i, int len, bit back, int dc,
                                        logic old, logic v);
    int   t1, t2;
    logic rise, fall, bsy, dout;
    rise = 1'b0; fall = 1'b0; bsy = 1'b0; dout = old;
    if (v != old) begin
      t1 = SS + dc - 1;
      if (len < dc) begin
        bsy = (i >= SS) && (i <= SS + len - 1);
      end else begin
        bsy  = (i >= SS) && (i < t1);
        dout = (i >= t1) ? v : old;
        if (i == t1) begin rise = v; fall = ~v; end
        if (back && i >= len + SS) begin
          t2   = len + SS + dc - 1;
          bsy  = (i < t2);
          dout = (i >= t2) ? old : v;
          if (i == t2) begin rise = old; fall = ~old; end
        end
      end
    end
    return {rise, fall, bsy, dout};
  endfunction

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  // driver: one segment, expectations pushed per upcoming edge
  task automatic seg(input logic v, input int len, input bit back);
    int total;
    total = back ? (len + SS + DC + 2) : len;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      d_in = (i < len) ? v : model;
      exp_q.push_back(mask_pulses(exp_at(i, len, back, DC, model, v)));
      exp1_q.push_back(mask_pulses(exp_at(i, len, back, 1, model, v)));
    end
    if (!back) model = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"}, act_a(), 4'b0000);
    check({tag, "_b"}, act_b(), 4'b0000);
  endtask

  // scoreboard: compare #1 after each active edge
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        e_a = exp_q.pop_front();
        check("dut_a", act_a(), e_a);
      end
      if (exp1_q.size() > 0) begin
        e_b = exp1_q.pop_front();
        check("dut_b", act_b(), e_b);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    d_in  = 1'b1;
    model = 1'b0;

    // reset held with d_in=1: outputs stay at reset value
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset_hold");
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    seg(1'b1, 10, 1'b0);

    // clean fall, glitch, clean rise, clean fall
    seg(1'b0, 10, 1'b0);
    seg(1'b1, 3, 1'b1);
    seg(1'b1, 10, 1'b0);
    seg(1'b0, 10, 1'b0);

    // random short glitches and clean steps
    for (int n = 0; n < 6; n++) begin
      seg(~model, $urandom_range(1, 3), 1'b1);
      seg(~model, $urandom_range(SS + DC, SS + DC + 4), 1'b0);
    end
    if (model) seg(1'b0, 10, 1'b0);

    repeat (3) @(negedge clk);
    check("drain_a", 4'(exp_q.size()), 4'd0);
    check("drain_b", 4'(exp1_q.size()), 4'd0);

    // reset asserted at edge k+4 of a rise
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d_in = 1'b1;
    end
    @(posedge clk);
    #2;
    check("mid_wait_a", act_a(), 4'b0010);
    check("mid_wait_b", {2'b00, busy_b, dout_b}, 4'b0001);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_abort");
    d_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset_abort_hold");
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    seg(1'b0, 10, 1'b0);
    seg(1'b1, 10, 1'b0);

    repeat (3) @(negedge clk);
    check("final_drain_a", 4'(exp_q.size()), 4'd0);
    check("final_drain_b", 4'(exp1_q.size()), 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
